// File: rtl/mac_dot_feeder.sv
// Operand-side initiator for a pipelined MAC: buffers one vector of operand pairs, streams it
// into the MAC and returns the dot product as (mac_out - baseline) on a valid/ready port.
module mac_dot_feeder #(
    parameter int DW      = 4,
    parameter int AW      = 9,
    parameter int DEPTH   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_a,
    input  logic [DW-1:0] wr_b,
    input  logic          wr_last,
    output logic [DW-1:0] mac_in1,
    output logic [DW-1:0] mac_in2,
    input  logic [AW-1:0] mac_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic          busy
);

    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DCW = $clog2(MAC_LAT + 2);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the source holds its data stable while valid is high and ready is low.

    logic [1:0]       state;
    logic [IW-1:0]    wcnt;
    logic [IW-1:0]    ridx;
    logic [IW-1:0]    last_idx;
    logic [DCW-1:0]   dcnt;
    logic [AW-1:0]    base;
    logic [2*DW-1:0]  pair_mem [DEPTH];

    logic wr_fire;
    logic vec_end;

    assign wr_ready = (state == FILL);
    assign busy     = (state != FILL);
    assign wr_fire  = wr_valid && wr_ready;
    assign vec_end  = wr_last || (wcnt == IW'(DEPTH - 1));

    // Buffer storage is never reset; only entries written in this vector are read back.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            pair_mem[wcnt] <= {wr_a, wr_b};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            wcnt      <= '0;
            ridx      <= '0;
            last_idx  <= '0;
            dcnt      <= '0;
            base      <= '0;
            mac_in1   <= '0;
            mac_in2   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                FILL: begin
                    mac_in1 <= '0;
                    mac_in2 <= '0;
                    if (wr_fire) begin
                        wcnt <= wcnt + 1'b1;
                        if (vec_end) begin
                            state    <= STREAM;
                            last_idx <= wcnt;
                            base     <= mac_out;
                            ridx     <= '0;
                        end
                    end
                end
                STREAM: begin
                    mac_in1 <= pair_mem[ridx][2*DW-1:DW];
                    mac_in2 <= pair_mem[ridx][DW-1:0];
                    ridx    <= ridx + 1'b1;
                    if (ridx == last_idx) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    mac_in1 <= '0;
                    mac_in2 <= '0;
                    dcnt    <= dcnt + 1'b1;
                    // The last pair reaches mac_out MAC_LAT edges after it was loaded.
                    if (dcnt == DCW'(MAC_LAT)) begin
                        res_data  <= mac_out - base;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                default: begin
                    mac_in1 <= '0;
                    mac_in2 <= '0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        wcnt      <= '0;
                        state     <= FILL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_feeder.sv
// Directed bench for mac_dot_feeder with a behavioural two-stage wrap-around MAC attached.
module tb_mac_dot_feeder;

    localparam int DW = 4;
    localparam int AW = 9;

    logic          clock;
    logic          reset;
    logic          mac_rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_a;
    logic [DW-1:0] wr_b;
    logic          wr_last;
    logic [DW-1:0] mac_in1;
    logic [DW-1:0] mac_in2;
    logic [AW-1:0] mac_out;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic          busy;

    int n_cmp;
    int n_bad;
    int n_cyc;

    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [AW-1:0] acc;

    mac_dot_feeder dut (
        .clock     (clock),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_last   (wr_last),
        .mac_in1   (mac_in1),
        .mac_in2   (mac_in2),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MAC model: operand registers, then an accumulator that is never cleared by the feeder reset.
    always_ff @(posedge clock or posedge mac_rst) begin
        if (mac_rst) begin
            r1  <= '0;
            r2  <= '0;
            acc <= '0;
        end else begin
            r1  <= mac_in1;
            r2  <= mac_in2;
            acc <= acc + ({5'b0, r1} * {5'b0, r2});
        end
    end
    assign mac_out = acc;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        wr_valid = 1'b1;
        wr_a     = a;
        wr_b     = b;
        wr_last  = last;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_res(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 50) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        if (!res_valid) cycles = 999;
    endtask

    task automatic consume(input logic [AW-1:0] exp_data);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        check("consume_valid_low", 16'(res_valid), 16'd0);
        check("consume_fill", 16'(wr_ready), 16'd1);
        check("consume_data_kept", 16'(res_data), 16'(exp_data));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        mac_rst   = 1'b1;
        wr_valid  = 1'b0;
        wr_a      = '0;
        wr_b      = '0;
        wr_last   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        mac_rst = 1'b0;

        // 1: idle after reset
        repeat (5) @(posedge clock);
        #1;
        check("rst_wr_ready", 16'(wr_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_mac_in1", 16'(mac_in1), 16'd0);
        check("rst_mac_in2", 16'(mac_in2), 16'd0);
        check("rst_res_valid", 16'(res_valid), 16'd0);
        check("rst_res_data", 16'(res_data), 16'd0);
        check("rst_mac_out", 16'(mac_out), 16'd0);

        // 2: (3,4),(5,6) -> 42, result 5 edges after the last handshake
        push(4'd3, 4'd4, 1'b0);
        push(4'd5, 4'd6, 1'b1);
        check("t2_busy", 16'(busy), 16'd1);
        check("t2_wr_ready", 16'(wr_ready), 16'd0);
        @(posedge clock);
        #1;
        check("t2_in1_p0", 16'(mac_in1), 16'd3);
        check("t2_in2_p0", 16'(mac_in2), 16'd4);
        @(posedge clock);
        #1;
        check("t2_in1_p1", 16'(mac_in1), 16'd5);
        check("t2_in2_p1", 16'(mac_in2), 16'd6);
        check("t2_no_early_valid", 16'(res_valid), 16'd0);
        wait_res(n_cyc);
        check("t2_latency", 16'(n_cyc + 2), 16'd5);
        check("t2_res_data", 16'(res_data), 16'd42);
        check("t2_drain_in1", 16'(mac_in1), 16'd0);
        consume(9'd42);

        // 3: full buffer of (15,15) without wr_last -> 1800 mod 512
        for (int i = 0; i < 8; i++) push(4'd15, 4'd15, 1'b0);
        check("t3_full_wr_ready", 16'(wr_ready), 16'd0);
        check("t3_full_busy", 16'(busy), 16'd1);
        wait_res(n_cyc);
        check("t3_latency", 16'(n_cyc), 16'd11);
        check("t3_res_data", 16'(res_data), 16'd264);
        consume(9'd264);

        // 4: back-to-back vector with a non-zero baseline
        push(4'd2, 4'd3, 1'b1);
        wait_res(n_cyc);
        check("t4_latency", 16'(n_cyc), 16'd4);
        check("t4_res_data", 16'(res_data), 16'd6);

        // 5: result back-pressure, offered pairs must be ignored
        wr_valid = 1'b1;
        wr_a     = 4'd7;
        wr_b     = 4'd7;
        wr_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check("t5_hold_valid", 16'(res_valid), 16'd1);
            check("t5_hold_data", 16'(res_data), 16'd6);
            check("t5_hold_wr_ready", 16'(wr_ready), 16'd0);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        consume(9'd6);
        check("t5_fill_busy", 16'(busy), 16'd0);
        push(4'd1, 4'd2, 1'b1);
        wait_res(n_cyc);
        check("t5_after_res_data", 16'(res_data), 16'd2);
        consume(9'd2);

        // 6: reset during STREAM discards the vector
        push(4'd3, 4'd3, 1'b0);
        push(4'd3, 4'd3, 1'b0);
        push(4'd3, 4'd3, 1'b0);
        push(4'd3, 4'd3, 1'b1);
        @(posedge clock);
        #1;
        check("t6_streaming", 16'(mac_in1), 16'd3);
        reset = 1'b1;
        #1;
        check("t6_rst_wr_ready", 16'(wr_ready), 16'd1);
        check("t6_rst_busy", 16'(busy), 16'd0);
        check("t6_rst_mac_in1", 16'(mac_in1), 16'd0);
        check("t6_rst_mac_in2", 16'(mac_in2), 16'd0);
        check("t6_rst_res_valid", 16'(res_valid), 16'd0);
        check("t6_rst_res_data", 16'(res_data), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("t6_no_stale_valid", 16'(res_valid), 16'd0);
        push(4'd1, 4'd1, 1'b1);
        wait_res(n_cyc);
        check("t6_latency", 16'(n_cyc), 16'd4);
        check("t6_res_data", 16'(res_data), 16'd1);
        consume(9'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
